// File: rtl/audio_play_ctrl_if.sv
// Bundle of the signals between the playback sequencer and its surroundings.
// It carries four groups of signals:
//   - recorder/SDRAM status and playback controls
//       sdram_init_done, voice_write_done, play_start, play_stop, loop_en, play_len
//   - read-FIFO port
//       rd_load, sys_rd, sys_data_in
//   - audio side
//       sample_out, sample_valid
//   - status
//       busy, play_done
// The slave modport is the sequencer's view. The master modport is the view
// of the environment that drives the controls and the FIFO data.
interface audio_play_ctrl_if #(
  parameter int LEN_W = 22
);
  logic             sdram_init_done;
  logic             voice_write_done;
  logic             play_start;
  logic             play_stop;
  logic             loop_en;
  logic [LEN_W-1:0] play_len;
  logic             rd_load;
  logic             sys_rd;
  logic [15:0]      sys_data_in;
  logic [15:0]      sample_out;
  logic             sample_valid;
  logic             busy;
  logic             play_done;

  modport master (
    output sdram_init_done, voice_write_done, play_start, play_stop, loop_en,
           play_len, sys_data_in,
    input  rd_load, sys_rd, sample_out, sample_valid, busy, play_done
  );

  modport slave (
    input  sdram_init_done, voice_write_done, play_start, play_stop, loop_en,
           play_len, sys_data_in,
    output rd_load, sys_rd, sample_out, sample_valid, busy, play_done
  );
endinterface

// File: rtl/audio_play_ctrl.sv
// Playback sequencer downstream of the SDRAM read FIFO.
// After a recording is stored, it does the following:
//   - pulses rd_load to rewind the read address;
//   - waits for the FIFO to prefill;
//   - pops one 16-bit sample per audio sample period and presents it to the DAC side.
// It supports single-shot playback, looping and abort.
// Ports:
//   clk    read-side clock (same clock as the FIFO read port)
//   rst_n  synchronous active-low reset
//   bus    audio_play_ctrl_if.slave, which carries the controls, the FIFO port,
//          the sample output and the status
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for an accepted play_start
// LOAD    | rd_load held high for LOAD_CYCLES clocks
// PREFILL | waiting PREFILL_CYCLES clocks for the read FIFO to fill
// PLAY    | one FIFO pop per CLK_DIV clocks until play_len samples are out
// DONE    | one-clock play_done pulse, then back to IDLE
module audio_play_ctrl #(
  parameter int CLK_DIV        = 1024,
  parameter int PREFILL_CYCLES = 2048,
  parameter int LOAD_CYCLES    = 4,
  parameter int LEN_W          = 22
) (
  input logic              clk,
  input logic              rst_n,
  audio_play_ctrl_if.slave bus
);
  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam int TMR_MAX = (PREFILL_CYCLES > LOAD_CYCLES) ? PREFILL_CYCLES : LOAD_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] LOAD_LAST = TMR_W'(LOAD_CYCLES - 1);
  localparam logic [TMR_W-1:0] PRE_LAST  = TMR_W'(PREFILL_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, PREFILL, PLAY, DONE} state_t;

  state_t           state, state_nx;
  logic [TMR_W-1:0] tmr, tmr_nx;
  logic [DIV_W-1:0] div, div_nx;
  logic [LEN_W-1:0] cnt, cnt_nx, cnt_inc;
  logic [LEN_W-1:0] len_r, len_nx;
  logic             rec_ok;
  logic             sample_cap;
  logic [15:0]      sample_hold;
  logic             rd_load, sys_rd, play_done;

  // The LOAD and PREFILL phases share one down-counter. Each phase ends when
  // the counter reaches zero.
  always_comb begin
    state_nx  = state;
    tmr_nx    = tmr;
    div_nx    = div;
    cnt_nx    = cnt;
    len_nx    = len_r;
    rd_load   = 1'b0;
    sys_rd    = 1'b0;
    play_done = 1'b0;
    cnt_inc   = cnt + LEN_W'(1);
    case (state)
      IDLE: begin
        if (bus.play_start && !bus.play_stop && bus.sdram_init_done && rec_ok &&
            (bus.play_len != '0)) begin
          len_nx   = bus.play_len;
          cnt_nx   = '0;
          tmr_nx   = LOAD_LAST;
          state_nx = LOAD;
        end
      end
      LOAD: begin
        rd_load = 1'b1;
        if (tmr == '0) begin
          tmr_nx   = PRE_LAST;
          state_nx = PREFILL;
        end else begin
          tmr_nx = tmr - TMR_W'(1);
        end
      end
      PREFILL: begin
        if (tmr == '0) begin
          div_nx   = '0;
          state_nx = PLAY;
        end else begin
          tmr_nx = tmr - TMR_W'(1);
        end
      end
      PLAY: begin
        sys_rd = (div == '0);
        div_nx = (div == DIV_LAST) ? '0 : div + DIV_W'(1);
        // sample_cap marks the cycle in which the popped word is on sys_data_in.
        if (sample_cap) begin
          cnt_nx = cnt_inc;
          if (cnt_inc == len_r) begin
            if (bus.loop_en) begin
              cnt_nx   = '0;
              tmr_nx   = LOAD_LAST;
              state_nx = LOAD;
            end else begin
              state_nx = DONE;
            end
          end
        end
      end
      DONE: begin
        // An abort landing on the last cycle still suppresses the completion pulse.
        play_done = !bus.play_stop;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if ((state != IDLE) && bus.play_stop) state_nx = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      tmr         <= '0;
      div         <= '0;
      cnt         <= '0;
      len_r       <= '0;
      rec_ok      <= 1'b0;
      sample_cap  <= 1'b0;
      sample_hold <= '0;
    end else begin
      state      <= state_nx;
      tmr        <= tmr_nx;
      div        <= div_nx;
      cnt        <= cnt_nx;
      len_r      <= len_nx;
      // An abort does not cancel the pending capture: the FIFO pop already happened.
      sample_cap <= sys_rd;
      if (bus.voice_write_done) rec_ok <= 1'b1;
      if (sample_cap) sample_hold <= bus.sys_data_in;
    end
  end

  // FIFO data is valid only in the cycle after sys_rd. It is passed straight
  // through during that cycle, so the strobe and the new value line up.
  assign bus.sample_out   = sample_cap ? bus.sys_data_in : sample_hold;
  assign bus.sample_valid = sample_cap;
  assign bus.rd_load      = rd_load;
  assign bus.sys_rd       = sys_rd;
  assign bus.busy         = (state != IDLE);
  assign bus.play_done    = play_done;
endmodule

// File: tb/tb_audio_play_ctrl.sv
// Testbench for audio_play_ctrl.
// A timeline model predicts every output on every cycle. It works from the
// start cycle of each playback pass, and the bench compares the DUT against
// it at each falling edge. Directed scenarios add hand-computed literal
// checks, and a randomized phase follows them.
module tb_audio_play_ctrl;
  localparam int CLK_DIV = 8;
  localparam int PRE     = 16;
  localparam int LOADC   = 4;
  localparam int LEN_W   = 22;
  localparam int FIRST_RD = 1 + LOADC + PRE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  audio_play_ctrl_if #(.LEN_W(LEN_W)) bus ();

  audio_play_ctrl #(
    .CLK_DIV(CLK_DIV), .PREFILL_CYCLES(PRE), .LOAD_CYCLES(LOADC), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  logic [15:0] mem [64];

  // Read FIFO: rd_load rewinds it; each pop shows its word one cycle later.
  int addr = 0;
  always begin : fifo
    logic r, s;
    @(negedge clk);
    r = bus.rd_load;
    s = bus.sys_rd;
    @(posedge clk);
    #1;
    if (r) addr = 0;
    else if (s) begin
      bus.sys_data_in = mem[addr % 64];
      addr++;
    end
  end

  // Timeline model.
  int          cyc = 0;
  bit          m_active = 0, m_fin = 0, m_rec = 0, m_stopcap = 0;
  int          m_t0 = 0, m_len = 0, m_stopk = 0;
  logic [15:0] m_out = '0;
  logic        e_load = 0, e_rd = 0, e_valid = 0, e_busy = 0, e_done = 0;
  logic [15:0] e_out = '0;
  int          e_k = 0;

  int load_cnt, rd_cnt, valid_cnt, done_cnt, busy_cnt;
  int rd_t[$];
  int vals[$];

  always @(negedge clk) begin : cmp
    int d, rel;
    d = cyc - m_t0;
    e_load  = m_active && (d >= 1) && (d <= LOADC);
    e_rd    = 1'b0;
    e_valid = m_stopcap;
    e_k     = m_stopk;
    if (m_active && !m_fin && d >= FIRST_RD) begin
      rel = d - FIRST_RD;
      if ((rel % CLK_DIV == 0) && (rel / CLK_DIV < m_len)) e_rd = 1'b1;
      if ((rel >= 1) && ((rel - 1) % CLK_DIV == 0) && ((rel - 1) / CLK_DIV < m_len)) begin
        e_valid = 1'b1;
        e_k     = (rel - 1) / CLK_DIV;
      end
    end
    e_out  = e_valid ? mem[e_k] : m_out;
    e_busy = m_active;
    e_done = m_active && m_fin && !bus.play_stop;
    chk("rd_load", 32'(bus.rd_load), 32'(e_load));
    chk("sys_rd", 32'(bus.sys_rd), 32'(e_rd));
    chk("sample_valid", 32'(bus.sample_valid), 32'(e_valid));
    chk("sample_out", 32'(bus.sample_out), 32'(e_out));
    chk("busy", 32'(bus.busy), 32'(e_busy));
    chk("play_done", 32'(bus.play_done), 32'(e_done));
    if (bus.rd_load) load_cnt++;
    if (bus.sys_rd) begin rd_cnt++; rd_t.push_back(cyc); end
    if (bus.sample_valid) begin valid_cnt++; vals.push_back(int'(bus.sample_out)); end
    if (bus.play_done) done_cnt++;
    if (bus.busy) busy_cnt++;
  end

  always @(posedge clk) begin : mdl
    int d;
    d = cyc - m_t0;
    if (!rst_n) begin
      m_active = 0; m_fin = 0; m_rec = 0; m_stopcap = 0; m_out = '0;
    end else begin
      if (e_valid) m_out = e_out;
      m_stopcap = 0;
      if (m_active) begin
        if (bus.play_stop) begin
          m_stopcap = e_rd;
          m_stopk   = (d - FIRST_RD) / CLK_DIV;
          m_active  = 0;
          m_fin     = 0;
        end else if (m_fin) begin
          m_active = 0;
          m_fin    = 0;
        end else if (d == FIRST_RD + CLK_DIV * (m_len - 1) + 1) begin
          if (bus.loop_en) m_t0 = cyc;
          else m_fin = 1;
        end
      end else if (bus.play_start && !bus.play_stop && bus.sdram_init_done && m_rec &&
                   bus.play_len != '0) begin
        m_active = 1;
        m_fin    = 0;
        m_t0     = cyc;
        m_len    = int'(bus.play_len);
      end
      if (bus.voice_write_done) m_rec = 1;
    end
    cyc++;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic clr();
    load_cnt = 0; rd_cnt = 0; valid_cnt = 0; done_cnt = 0; busy_cnt = 0;
    rd_t.delete();
    vals.delete();
  endtask

  task automatic start(input int len, input bit lp, output int s);
    bus.play_len = LEN_W'(len);
    bus.loop_en = lp;
    bus.play_start = 1'b1;
    s = cyc;
    tick(1);
    bus.play_start = 1'b0;
  endtask

  task automatic pulse_vwd();
    bus.voice_write_done = 1'b1;
    tick(1);
    bus.voice_write_done = 1'b0;
  endtask

  initial begin
    int s;
    for (int i = 0; i < 64; i++) mem[i] = 16'(i + 1);
    bus.sdram_init_done = 0; bus.voice_write_done = 0; bus.play_start = 0;
    bus.play_stop = 0; bus.loop_en = 0; bus.play_len = '0; bus.sys_data_in = '0;
    clr();
    rst_n = 0;
    tick(3);
    rst_n = 1;
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_sample_out", 32'(bus.sample_out), 0);

    // Start before any recording is stored.
    bus.sdram_init_done = 1;
    clr();
    start(5, 0, s);
    tick(10);
    chk("no_rec_load", load_cnt, 0);
    chk("no_rec_busy", busy_cnt, 0);

    // Single-shot playback of 5 samples.
    pulse_vwd();
    clr();
    start(5, 0, s);
    tick(70);
    chk("load_len", load_cnt, 4);
    chk("rd_count", rd_cnt, 5);
    chk("valid_count", valid_cnt, 5);
    chk("done_count", done_cnt, 1);
    chk("busy_end", 32'(bus.busy), 0);
    chk("held_sample", 32'(bus.sample_out), 5);
    if (rd_t.size() > 0) chk("first_rd_latency", rd_t[0] - s, 21);
    for (int i = 1; i < rd_t.size(); i++) chk("rd_spacing", rd_t[i] - rd_t[i-1], CLK_DIV);
    for (int i = 0; i < vals.size(); i++) chk("sample_value", vals[i], i + 1);

    // Looped playback of 3 samples, then abort.
    clr();
    start(3, 1, s);
    tick(70);
    chk("loop_load_cycles", load_cnt, 8);
    chk("loop_no_done", done_cnt, 0);
    chk("loop_busy", 32'(bus.busy), 1);
    if (rd_t.size() > 3) chk("loop_resume_rd", rd_t[3] - s, 59);
    else chk("loop_rd_count", rd_t.size(), 4);
    bus.play_stop = 1;
    tick(1);
    bus.play_stop = 0;
    bus.loop_en = 0;
    tick(2);
    chk("loop_stop_busy", 32'(bus.busy), 0);

    // Abort on the cycle of the second FIFO read.
    clr();
    start(5, 0, s);
    tick(28);
    bus.play_stop = 1;
    tick(1);
    bus.play_stop = 0;
    tick(30);
    chk("stop_rd_count", rd_cnt, 2);
    chk("stop_valid_count", valid_cnt, 2);
    chk("stop_no_done", done_cnt, 0);
    chk("stop_busy", 32'(bus.busy), 0);
    chk("stop_sample", 32'(bus.sample_out), 2);

    // Zero length, and start together with stop.
    clr();
    start(0, 0, s);
    bus.play_stop = 1;
    start(5, 0, s);
    bus.play_stop = 0;
    tick(5);
    chk("idle_busy", busy_cnt, 0);
    chk("idle_load", load_cnt, 0);

    // Reset in the middle of PREFILL.
    start(5, 0, s);
    tick(10);
    rst_n = 0;
    tick(1);
    rst_n = 1;
    chk("rst_pre_busy", 32'(bus.busy), 0);
    chk("rst_pre_sample", 32'(bus.sample_out), 0);
    clr();
    start(5, 0, s);
    tick(5);
    chk("rst_pre_rec_cleared", load_cnt, 0);

    // Reset in the middle of PLAY.
    pulse_vwd();
    start(5, 0, s);
    tick(30);
    rst_n = 0;
    tick(1);
    rst_n = 1;
    chk("rst_play_busy", 32'(bus.busy), 0);
    chk("rst_play_sample", 32'(bus.sample_out), 0);
    chk("rst_play_valid", 32'(bus.sample_valid), 0);
    clr();
    start(5, 0, s);
    tick(5);
    chk("rst_play_rec_cleared", busy_cnt, 0);

    // Randomized traffic.
    for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
    for (int n = 0; n < 4000; n++) begin
      rst_n = ($urandom_range(0, 999) != 0);
      bus.voice_write_done = ($urandom_range(0, 49) == 0);
      bus.sdram_init_done = ($urandom_range(0, 19) != 0);
      bus.play_start = ($urandom_range(0, 29) == 0);
      bus.play_stop = ($urandom_range(0, 149) == 0);
      bus.loop_en = 1'($urandom_range(0, 1));
      bus.play_len = LEN_W'($urandom_range(0, 4));
      tick(1);
    end
    rst_n = 1;
    bus.voice_write_done = 0; bus.play_start = 0; bus.play_stop = 0; bus.loop_en = 0;
    tick(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
